key_event_ctrl: RTL and testbench

Event controller for a bank of debounced keys. It takes the stable key levels from the per-key debounce instances and detects press, release and long-press events for each key. A round-robin arbiter schedules these events onto one valid/ready event port that the downstream UI or CPU logic consumes. Events that are still waiting are buffered per key and type, and any event lost to overflow is flagged.

---
 rtl/key_event_ctrl.sv | 147 ++++++++++++++
 tb/tb_key_event_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_event_ctrl.sv
// Turns debounced key levels into press / release / long-press events and
// serialises them onto one valid/ready port with a round-robin pick over keys.
module key_event_ctrl #(
  parameter int   KEY_NUM    = 4,
  parameter logic KEY_ACTIVE = 1'b0,
  parameter int   LONG_CNT   = 100_000_000
) (
  input  logic               sysclk,
  input  logic               rst,
  input  logic [KEY_NUM-1:0] key_in,
  output logic               ev_valid,
  input  logic               ev_ready,
  output logic [3:0]         ev_key,
  output logic [1:0]         ev_type,
  output logic               ev_lost
);

  localparam int             CW           = $clog2(LONG_CNT + 1);
  localparam logic [CW-1:0]  CNT_MAX      = CW'(LONG_CNT);
  localparam logic [CW-1:0]  CNT_PRE      = CW'(LONG_CNT - 1);
  localparam logic [3:0]     LAST_KEY     = 4'(KEY_NUM - 1);
  localparam logic [1:0]     TYPE_PRESS   = 2'b01;
  localparam logic [1:0]     TYPE_RELEASE = 2'b10;
  localparam logic [1:0]     TYPE_LONG    = 2'b11;

  logic [KEY_NUM-1:0] key_q;
  logic [KEY_NUM-1:0] key_p;
  logic [CW-1:0]      hold_cnt [KEY_NUM];

  logic [KEY_NUM-1:0] press_det;
  logic [KEY_NUM-1:0] rel_det;
  logic [KEY_NUM-1:0] long_det;

  logic [KEY_NUM-1:0] pend_press;
  logic [KEY_NUM-1:0] pend_long;
  logic [KEY_NUM-1:0] pend_rel;
  logic [KEY_NUM-1:0] clr_press;
  logic [KEY_NUM-1:0] clr_long;
  logic [KEY_NUM-1:0] clr_rel;
  logic [KEY_NUM-1:0] key_pend;

  logic [3:0] rr;
  logic [3:0] hi_key;
  logic [3:0] lo_key;
  logic       hi_found;
  logic [3:0] sel_key;
  logic [1:0] sel_type;
  logic       load;
  logic       lost_now;

  assign press_det = key_q & ~key_p;
  assign rel_det   = ~key_q & key_p;
  assign key_pend  = pend_press | pend_long | pend_rel;
  assign load      = (~ev_valid | ev_ready) & (|key_pend);

  // The long pulse marks the single step from LONG_CNT-1 to the saturated value.
  always_comb begin
    long_det = '0;
    for (int i = 0; i < KEY_NUM; i++) begin
      long_det[i] = key_q[i] && (hold_cnt[i] == CNT_PRE);
    end
  end

  // Lowest pending key at or above rr wins; otherwise wrap to the lowest pending key.
  always_comb begin
    hi_found = 1'b0;
    hi_key   = '0;
    lo_key   = '0;
    for (int i = KEY_NUM - 1; i >= 0; i--) begin
      if (key_pend[i]) begin
        lo_key = 4'(i);
        if (4'(i) >= rr) begin
          hi_key   = 4'(i);
          hi_found = 1'b1;
        end
      end
    end
    sel_key = hi_found ? hi_key : lo_key;
  end

  always_comb begin
    sel_type  = TYPE_RELEASE;
    clr_press = '0;
    clr_long  = '0;
    clr_rel   = '0;
    for (int i = 0; i < KEY_NUM; i++) begin
      if (4'(i) == sel_key) begin
        if (pend_press[i]) begin
          sel_type = TYPE_PRESS;
        end else if (pend_long[i]) begin
          sel_type = TYPE_LONG;
        end
      end
    end
    for (int i = 0; i < KEY_NUM; i++) begin
      clr_press[i] = load && (4'(i) == sel_key) && (sel_type == TYPE_PRESS);
      clr_long[i]  = load && (4'(i) == sel_key) && (sel_type == TYPE_LONG);
      clr_rel[i]   = load && (4'(i) == sel_key) && (sel_type == TYPE_RELEASE);
    end
  end

  // A new event only drops when its slot stays occupied past this edge.
  assign lost_now = |((press_det & pend_press & ~clr_press) |
                      (long_det  & pend_long  & ~clr_long)  |
                      (rel_det   & pend_rel   & ~clr_rel));

  always_ff @(posedge sysclk) begin
    if (rst) begin
      key_q      <= '0;
      key_p      <= '0;
      pend_press <= '0;
      pend_long  <= '0;
      pend_rel   <= '0;
      rr         <= '0;
      ev_valid   <= 1'b0;
      ev_key     <= '0;
      ev_type    <= '0;
      ev_lost    <= 1'b0;
      for (int i = 0; i < KEY_NUM; i++) begin
        hold_cnt[i] <= '0;
      end
    end else begin
      key_q <= KEY_ACTIVE ? key_in : ~key_in;
      key_p <= key_q;
      for (int i = 0; i < KEY_NUM; i++) begin
        if (!key_q[i]) begin
          hold_cnt[i] <= '0;
        end else if (hold_cnt[i] != CNT_MAX) begin
          hold_cnt[i] <= hold_cnt[i] + CW'(1);
        end
      end
      pend_press <= (pend_press & ~clr_press) | press_det;
      pend_long  <= (pend_long  & ~clr_long)  | long_det;
      pend_rel   <= (pend_rel   & ~clr_rel)   | rel_det;
      ev_lost    <= lost_now;
      if (load) begin
        ev_valid <= 1'b1;
        ev_key   <= sel_key;
        ev_type  <= sel_type;
        rr       <= (sel_key == LAST_KEY) ? 4'd0 : sel_key + 4'd1;
      end else if (ev_ready) begin
        ev_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_key_event_ctrl.sv
// Scoreboard bench for key_event_ctrl: stimulus predicts event order from the
// key-level rules, a monitor pops and compares every accepted event.
module tb_key_event_ctrl;

  localparam int KEY_NUM  = 4;
  localparam int LONG_CNT = 8;

  typedef struct packed {
    logic [3:0] key;
    logic [1:0] kind;
  } event_t;

  logic       sysclk = 1'b0;
  logic       rst;
  logic [3:0] key_in;
  logic       ev_valid;
  logic       ev_ready;
  logic [3:0] ev_key;
  logic [1:0] ev_type;
  logic       ev_lost;

  event_t exp_q[$];
  int     checks = 0;
  int     failures = 0;
  int     cyc = 0;
  int     lost_cnt = 0;
  int     model_rr = 0;
  bit     rand_ready = 1'b0;
  bit     ready_cmd = 1'b1;
  int     press_t0;
  int     first_press_cyc;
  int     last_press_cyc;
  int     long_cyc;
  int     valid_cycles;
  int     lost_ref;

  key_event_ctrl #(
    .KEY_NUM   (KEY_NUM),
    .KEY_ACTIVE(1'b0),
    .LONG_CNT  (LONG_CNT)
  ) dut (
    .sysclk  (sysclk),
    .rst     (rst),
    .key_in  (key_in),
    .ev_valid(ev_valid),
    .ev_ready(ev_ready),
    .ev_key  (ev_key),
    .ev_type (ev_type),
    .ev_lost (ev_lost)
  );

  initial forever #5 sysclk = ~sysclk;

  always @(posedge sysclk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    end
  endtask

  // Accepted events are compared in order against the predicted queue.
  initial begin
    event_t e;
    forever begin
      @(negedge sysclk);
      if (!rst && ev_lost === 1'b1) lost_cnt++;
      if (!rst && ev_valid === 1'b1 && ev_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_event: got key=%0d type=%b, want none", ev_key, ev_type);
        end else begin
          e = exp_q.pop_front();
          checkOutput("event", {26'd0, ev_key, ev_type}, {26'd0, e});
        end
      end
    end
  end

  task automatic tick();
    @(posedge sysclk);
    #1;
    ev_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_cmd;
  endtask

  task automatic stepSample();
    tick();
    @(negedge sysclk);
    if (ev_valid === 1'b1) begin
      valid_cycles++;
      if (ev_type == 2'b01) begin
        if (first_press_cyc < 0) first_press_cyc = cyc;
        last_press_cyc = cyc;
      end
      if (ev_type == 2'b11 && long_cyc < 0) long_cyc = cyc;
    end
  endtask

  task automatic pushEv(input int key, input logic [1:0] kind);
    event_t e;
    e.key  = 4'(key);
    e.kind = kind;
    exp_q.push_back(e);
  endtask

  // Keys that share an event type are served as one sweep starting at the pointer.
  task automatic pushLap(input logic [3:0] mask, input logic [1:0] kind);
    int last = -1;
    for (int k = 0; k < KEY_NUM; k++) begin
      int idx = (model_rr + k) % KEY_NUM;
      if (mask[idx]) begin
        pushEv(idx, kind);
        last = idx;
      end
    end
    if (last >= 0) model_rr = (last + 1) % KEY_NUM;
  endtask

  task automatic waitDrain();
    int n = 0;
    do begin
      stepSample();
      n++;
    end while ((exp_q.size() != 0 || ev_valid !== 1'b0) && n < 300);
    checkOutput("drain", {ev_valid, 31'(exp_q.size())}, 32'd0);
  endtask

  // Press the keys in mask together for hold cycles, release, and let it drain.
  task automatic applyStimulus(input logic [3:0] mask, input int hold);
    first_press_cyc = -1;
    last_press_cyc  = -1;
    long_cyc        = -1;
    valid_cycles    = 0;
    pushLap(mask, 2'b01);
    if (hold >= LONG_CNT) pushLap(mask, 2'b11);
    pushLap(mask, 2'b10);
    key_in   = ~mask;
    press_t0 = cyc + 1;
    repeat (hold) stepSample();
    key_in = 4'hF;
    waitDrain();
  endtask

  initial begin
    rst       = 1'b1;
    key_in    = 4'hF;
    ev_ready  = 1'b1;
    ready_cmd = 1'b1;
    repeat (2) stepSample();
    checkOutput("reset_outputs", {25'd0, ev_valid, ev_key, ev_type, ev_lost}, 32'd0);
    rst = 1'b0;
    stepSample();

    applyStimulus(4'b1111, 3);
    checkOutput("rr_order_back_to_back", last_press_cyc - first_press_cyc, 3);
    checkOutput("rr_press_latency", first_press_cyc - press_t0, 2);

    applyStimulus(4'b0010, 3);
    applyStimulus(4'b1111, 3);
    checkOutput("rr_from2_back_to_back", last_press_cyc - first_press_cyc, 3);

    applyStimulus(4'b0001, 4);
    checkOutput("single_press_latency", first_press_cyc - press_t0, 2);
    checkOutput("single_valid_cycles", valid_cycles, 2);
    checkOutput("single_no_long", long_cyc, -1);

    applyStimulus(4'b0100, 12);
    checkOutput("long_latency", long_cyc - press_t0, LONG_CNT + 1);
    checkOutput("long_valid_cycles", valid_cycles, 3);

    applyStimulus(4'b0010, LONG_CNT - 1);
    checkOutput("hold_below_long", long_cyc, -1);
    applyStimulus(4'b0010, LONG_CNT);
    checkOutput("hold_at_long", long_cyc - press_t0, LONG_CNT + 1);

    // Backpressure: the first event must sit unchanged while ready is low.
    ready_cmd = 1'b0;
    stepSample();
    pushLap(4'b0010, 2'b01);
    pushLap(4'b0010, 2'b10);
    key_in = 4'b1101;
    repeat (3) stepSample();
    key_in = 4'hF;
    for (int i = 0; i < 20; i++) begin
      stepSample();
      checkOutput($sformatf("bp_hold_%0d", i), {25'd0, ev_valid, ev_key, ev_type}, {25'd0, 1'b1, 4'd1, 2'b01});
    end
    ready_cmd = 1'b1;
    repeat (3) stepSample();
    checkOutput("bp_valid_drops", {31'd0, ev_valid}, 32'd0);
    checkOutput("bp_queue", exp_q.size(), 0);

    // Overflow: key 0 occupies the output, key 3 cycles twice behind it.
    ready_cmd = 1'b0;
    stepSample();
    lost_ref = lost_cnt;
    pushEv(0, 2'b01);
    pushEv(3, 2'b01);
    pushEv(0, 2'b10);
    pushEv(3, 2'b10);
    model_rr = 0;
    key_in = 4'b1110; repeat (3) stepSample();
    key_in = 4'b1111; repeat (3) stepSample();
    for (int r = 0; r < 2; r++) begin
      key_in = 4'b0111; repeat (3) stepSample();
      key_in = 4'b1111; repeat (3) stepSample();
    end
    repeat (2) stepSample();
    checkOutput("ovf_lost_pulses", lost_cnt - lost_ref, 2);
    checkOutput("ovf_output_held", {25'd0, ev_valid, ev_key, ev_type}, {25'd0, 1'b1, 4'd0, 2'b01});
    ready_cmd = 1'b1;
    waitDrain();
    checkOutput("ovf_lost_after_drain", lost_cnt - lost_ref, 2);

    lost_ref   = lost_cnt;
    rand_ready = 1'b1;
    for (int it = 0; it < 25; it++) begin
      applyStimulus(4'($urandom_range(1, 15)), $urandom_range(2, 14));
    end
    rand_ready = 1'b0;
    ready_cmd  = 1'b1;
    checkOutput("random_no_loss", lost_cnt - lost_ref, 0);

    // Reset while one event is presented and three more are waiting.
    ready_cmd = 1'b0;
    stepSample();
    key_in = 4'b0000;
    repeat (4) stepSample();
    checkOutput("midreset_pre_valid", {31'd0, ev_valid}, 32'd1);
    lost_ref = lost_cnt;
    rst    = 1'b1;
    key_in = 4'hF;
    stepSample();
    checkOutput("midreset_outputs", {25'd0, ev_valid, ev_key, ev_type, ev_lost}, 32'd0);
    rst = 1'b0;
    exp_q.delete();
    model_rr     = 0;
    ready_cmd    = 1'b1;
    valid_cycles = 0;
    repeat (20) stepSample();
    checkOutput("midreset_no_events", valid_cycles, 0);
    checkOutput("midreset_no_lost", lost_cnt - lost_ref, 0);
    applyStimulus(4'b1111, 3);
    checkOutput("midreset_rr_restart", first_press_cyc - press_t0, 2);

    // A key held through reset shows up as a fresh press afterwards.
    rst    = 1'b1;
    key_in = 4'b1110;
    repeat (2) stepSample();
    rst = 1'b0;
    exp_q.delete();
    model_rr = 0;
    pushLap(4'b0001, 2'b01);
    pushLap(4'b0001, 2'b10);
    repeat (3) stepSample();
    key_in = 4'hF;
    waitDrain();

    checkOutput("final_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
